// File: rtl/vm_pkg.sv
// Shared definitions for the vend/change dispense path: change codes, queue entry
// layout and dispense FSM encoding.
package vm_pkg;

    localparam logic [1:0] CHG_NONE = 2'b00;
    localparam logic [1:0] CHG_5    = 2'b01;
    localparam logic [1:0] CHG_10   = 2'b10;
    localparam logic [1:0] CHG_BAD  = 2'b11;

    localparam int COIN_UNIT = 5;
    localparam int ENTRY_W   = 3;

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_LOAD       = 3'd1;
    localparam logic [2:0] ST_PROD_PULSE = 3'd2;
    localparam logic [2:0] ST_PROD_WAIT  = 3'd3;
    localparam logic [2:0] ST_COIN_PULSE = 3'd4;
    localparam logic [2:0] ST_COIN_WAIT  = 3'd5;
    localparam logic [2:0] ST_FAULT      = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE       = ST_IDLE,
        S_LOAD       = ST_LOAD,
        S_PROD_PULSE = ST_PROD_PULSE,
        S_PROD_WAIT  = ST_PROD_WAIT,
        S_COIN_PULSE = ST_COIN_PULSE,
        S_COIN_WAIT  = ST_COIN_WAIT,
        S_FAULT      = ST_FAULT
    } state_t;

    typedef struct packed {
        logic       vend;
        logic [1:0] coins;
    } entry_t;

    // Number of COIN_UNIT coins the hopper must eject for a change code.
    function automatic logic [1:0] coins_of(input logic [1:0] chg);
        case (chg)
            CHG_5:   return 2'(5 / COIN_UNIT);
            CHG_10:  return 2'(10 / COIN_UNIT);
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/vm_req_fifo.sv
// Synchronous request FIFO; pointers carry an extra MSB to tell full from empty.
module vm_req_fifo
    import vm_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int WIDTH      = ENTRY_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is accepted.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: storage is not reset; the pointers alone define which entries are valid.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/vend_dispense_ctrl.sv
// Queues vend/change requests and drives the product solenoid and coin hopper with
// pulse/ack handshakes, retrying on stalls and latching a sticky fault.
module vend_dispense_ctrl
    import vm_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int PULSE_CYCLES   = 4,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int MAX_RETRY      = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       vend,
    input  logic [1:0] change,
    input  logic       prod_ack,
    input  logic       coin_ack,
    output logic       prod_release,
    output logic       coin_eject,
    output logic       busy,
    output logic       fault,
    output logic       overflow,
    output logic       bad_code
);

    localparam int CNT_MAX = (PULSE_CYCLES > TIMEOUT_CYCLES) ? PULSE_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int RTY_W   = $clog2(MAX_RETRY + 2);

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [RTY_W-1:0]   retry, retry_n;
    logic [1:0]         coins_q, coins_n;

    logic               cap_push;
    entry_t             cap_entry;
    entry_t             head;
    logic [ENTRY_W-1:0] fifo_dout;
    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_pop;

    assign cap_push  = vend || ((change != CHG_NONE) && (change != CHG_BAD));
    assign cap_entry = '{vend: vend, coins: coins_of(change)};
    assign fifo_pop  = (state == S_LOAD);
    assign head      = entry_t'(fifo_dout);

    vm_req_fifo #(.FIFO_DEPTH(FIFO_DEPTH), .WIDTH(ENTRY_W)) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (cap_push),
        .pop   (fifo_pop),
        .din   (cap_entry),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // NOTE: sequential state uses non-blocking assignments; the always_comb below uses
    // blocking ones and sets every output first so no latch is inferred.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            retry    <= '0;
            coins_q  <= '0;
            overflow <= 1'b0;
            bad_code <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            retry    <= retry_n;
            coins_q  <= coins_n;
            overflow <= overflow || (cap_push && fifo_full && !fifo_pop);
            bad_code <= bad_code || (change == CHG_BAD);
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        retry_n = retry;
        coins_n = coins_q;
        case (state)
            S_IDLE: begin
                if (!fifo_empty) state_n = S_LOAD;
            end
            S_LOAD: begin
                coins_n = head.coins;
                cnt_n   = '0;
                retry_n = '0;
                if (head.vend)            state_n = S_PROD_PULSE;
                else if (head.coins != 0) state_n = S_COIN_PULSE;
                else                      state_n = S_IDLE;
            end
            S_PROD_PULSE, S_COIN_PULSE: begin
                if (cnt == CNT_W'(PULSE_CYCLES - 1)) begin
                    cnt_n   = '0;
                    state_n = (state == S_PROD_PULSE) ? S_PROD_WAIT : S_COIN_WAIT;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            S_PROD_WAIT: begin
                if (prod_ack) begin
                    cnt_n   = '0;
                    retry_n = '0;
                    state_n = (coins_q != 0) ? S_COIN_PULSE : S_IDLE;
                end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    cnt_n = '0;
                    if (retry < RTY_W'(MAX_RETRY)) begin
                        retry_n = retry + 1'b1;
                        state_n = S_PROD_PULSE;
                    end else begin
                        state_n = S_FAULT;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            S_COIN_WAIT: begin
                // One ack per ejected coin; the item completes when the last coin is out.
                if (coin_ack) begin
                    cnt_n   = '0;
                    retry_n = '0;
                    coins_n = coins_q - 1'b1;
                    state_n = (coins_q == 2'd1) ? S_IDLE : S_COIN_PULSE;
                end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    cnt_n = '0;
                    if (retry < RTY_W'(MAX_RETRY)) begin
                        retry_n = retry + 1'b1;
                        state_n = S_COIN_PULSE;
                    end else begin
                        state_n = S_FAULT;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            S_FAULT: state_n = S_FAULT;
            default: state_n = S_IDLE;
        endcase
    end

    assign prod_release = (state == S_PROD_PULSE);
    assign coin_eject   = (state == S_COIN_PULSE);
    assign fault        = (state == S_FAULT);
    assign busy         = (state != S_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_vend_dispense_ctrl.sv
// Directed bench for vend_dispense_ctrl: latency, coin handshakes, overflow, stall
// retry/fault, illegal change code and mid-pulse reset.
module tb_vend_dispense_ctrl;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       vend = 1'b0;
    logic [1:0] change = 2'b00;
    logic       prod_ack = 1'b0;
    logic       coin_ack = 1'b0;
    logic       prod_release;
    logic       coin_eject;
    logic       busy;
    logic       fault;
    logic       overflow;
    logic       bad_code;

    int tests_run = 0;
    int tests_failed = 0;
    int prod_pulses = 0;
    int coin_pulses = 0;
    logic prod_prev = 1'b0;
    logic coin_prev = 1'b0;

    vend_dispense_ctrl dut (
        .clock        (clock),
        .reset        (reset),
        .vend         (vend),
        .change       (change),
        .prod_ack     (prod_ack),
        .coin_ack     (coin_ack),
        .prod_release (prod_release),
        .coin_eject   (coin_eject),
        .busy         (busy),
        .fault        (fault),
        .overflow     (overflow),
        .bad_code     (bad_code)
    );

    always #5 clock = ~clock;

    // Rising-edge counters for both actuator drives, sampled mid-cycle.
    always @(negedge clock) begin
        if (prod_release === 1'b1 && prod_prev !== 1'b1) prod_pulses++;
        if (coin_eject === 1'b1 && coin_prev !== 1'b1) coin_pulses++;
        prod_prev = prod_release;
        coin_prev = coin_eject;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Wait (bounded) for the chosen drive to rise, then count its high cycles.
    task automatic pulse_len(input logic is_coin, output int len);
        int t;
        t = 0;
        len = 0;
        while ((is_coin ? coin_eject : prod_release) !== 1'b1 && t < 300) begin
            tick();
            t++;
        end
        while ((is_coin ? coin_eject : prod_release) === 1'b1 && len < 50) begin
            tick();
            len++;
        end
    endtask

    // Measure one pulse, then raise the matching ack for one cycle ack_delay cycles
    // after the pulse ends.
    task automatic service_pulse(input logic is_coin, input int ack_delay, output int len);
        pulse_len(is_coin, len);
        repeat (ack_delay - 1) tick();
        if (is_coin) coin_ack = 1'b1;
        else         prod_ack = 1'b1;
        tick();
        coin_ack = 1'b0;
        prod_ack = 1'b0;
    endtask

    initial begin
        int len;
        int len2;
        int t;
        int p0;
        int c0;
        logic any_drive;

        // Reset state
        do_reset();
        check("rst_prod_release", prod_release, 0);
        check("rst_coin_eject", coin_eject, 0);
        check("rst_busy", busy, 0);
        check("rst_flags", {fault, overflow, bad_code}, 0);

        // 1: plain vend, latency N+3, 4-cycle pulse, ack 2 cycles after pulse end
        p0 = prod_pulses;
        c0 = coin_pulses;
        vend = 1'b1;
        tick();
        vend = 1'b0;
        check("t1_busy_after_push", busy, 1);
        check("t1_prod_n1", prod_release, 0);
        tick();
        check("t1_prod_n2_load", prod_release, 0);
        tick();
        check("t1_prod_n3", prod_release, 1);
        service_pulse(1'b0, 2, len);
        check("t1_prod_len", len, 4);
        check("t1_busy_idle", busy, 0);
        check("t1_prod_count", prod_pulses - p0, 1);
        check("t1_no_coin", coin_pulses - c0, 0);
        check("t1_flags", {fault, overflow, bad_code}, 0);

        // 2: vend with 10-unit change -> one product pulse, two coin pulses
        p0 = prod_pulses;
        c0 = coin_pulses;
        vend = 1'b1;
        change = 2'b10;
        tick();
        vend = 1'b0;
        change = 2'b00;
        service_pulse(1'b0, 1, len);
        check("t2_prod_len", len, 4);
        check("t2_coin1_starts", coin_eject, 1);
        service_pulse(1'b1, 1, len);
        check("t2_coin1_len", len, 4);
        service_pulse(1'b1, 1, len);
        check("t2_coin2_len", len, 4);
        check("t2_busy_idle", busy, 0);
        check("t2_prod_count", prod_pulses - p0, 1);
        check("t2_coin_count", coin_pulses - c0, 2);

        // 3: six back-to-back vends with no ack -> overflow, then fault after 3 timeouts
        p0 = prod_pulses;
        vend = 1'b1;
        t = 0;
        while (fault !== 1'b1 && t < 400) begin
            tick();
            t++;
            if (t == 6) vend = 1'b0;
        end
        vend = 1'b0;
        check("t3_cycles_to_fault", t, 207);
        check("t3_prod_attempts", prod_pulses - p0, 3);
        check("t3_overflow", overflow, 1);
        check("t3_fault", fault, 1);
        any_drive = 1'b0;
        repeat (20) begin
            tick();
            any_drive = any_drive | prod_release | coin_eject;
        end
        check("t3_drives_idle", any_drive, 0);
        check("t3_fault_sticky", fault, 1);
        check("t3_busy", busy, 1);

        // 4: coin stall -> timeout, retry pulse acked, no fault
        do_reset();
        check("t4_flags_cleared", {fault, overflow, bad_code}, 0);
        c0 = coin_pulses;
        change = 2'b01;
        tick();
        change = 2'b00;
        pulse_len(1'b1, len);
        check("t4_coin1_len", len, 4);
        t = 0;
        while (coin_eject !== 1'b1 && t < 200) begin
            tick();
            t++;
        end
        check("t4_timeout_cycles", t, 64);
        service_pulse(1'b1, 1, len2);
        check("t4_retry_len", len2, 4);
        check("t4_coin_count", coin_pulses - c0, 2);
        check("t4_fault", fault, 0);
        check("t4_busy_idle", busy, 0);

        // 5: illegal change code alone -> bad_code, nothing queued
        p0 = prod_pulses;
        c0 = coin_pulses;
        change = 2'b11;
        tick();
        change = 2'b00;
        check("t5_bad_code", bad_code, 1);
        check("t5_busy", busy, 0);
        repeat (4) tick();
        check("t5_busy_later", busy, 0);
        check("t5_no_drives", (prod_pulses - p0) + (coin_pulses - c0), 0);

        // 6: reset during the 2nd cycle of prod_release with a second item queued
        vend = 1'b1;
        tick();
        tick();
        vend = 1'b0;
        t = 0;
        while (prod_release !== 1'b1 && t < 20) begin
            tick();
            t++;
        end
        tick();
        check("t6_pulse_cycle2", prod_release, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t6_prod_dropped", prod_release, 0);
        check("t6_busy", busy, 0);
        check("t6_flags", {fault, overflow, bad_code}, 0);
        repeat (5) tick();
        check("t6_fifo_empty", busy, 0);
        check("t6_no_restart", prod_release, 0);
        vend = 1'b1;
        tick();
        vend = 1'b0;
        service_pulse(1'b0, 1, len);
        check("t6_new_len", len, 4);
        check("t6_new_idle", busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
